// File: rtl/pkt_fifo_reader.sv
// pkt_fifo_reader: pops length-prefixed packets from a first-word-fall-through
// FIFO, strips the header and presents the payload as a valid/ready stream
// with start/end-of-packet markers.
// Optional build macro: PKT_RD_STAT_EN adds packet / zero-length statistics.
module pkt_fifo_reader #(
  parameter int pDATA_W    = 8,
  parameter int pHDR_WORDS = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               ienable,
  input  logic               ififo_empty,
  input  logic [pDATA_W-1:0] ififo_data,
  output logic               ofifo_rd,
  output logic [pDATA_W-1:0] odata,
  output logic               ovalid,
  output logic               osop,
  output logic               oeop,
  input  logic               iready,
  output logic               obusy
`ifdef PKT_RD_STAT_EN
  ,
  output logic [15:0]        ostat_pkt_cnt,
  output logic [7:0]         ostat_zero_cnt
`endif
);

  localparam int LEN_W = pHDR_WORDS * pDATA_W;
  localparam int CNT_W = (pHDR_WORDS > 1) ? $clog2(pHDR_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_remain;
  logic [CNT_W-1:0]   r_hdr_cnt;

  logic [LEN_W-1:0]   w_len_shift;
  logic               w_hdr_last;
  logic               w_hdr_pop;
  logic               w_xfer;
  logic               w_zero_len;

  // Header words arrive MSB first: shift the running length left by one word.
  assign w_len_shift = (r_len << pDATA_W) | LEN_W'(ififo_data);
  assign w_hdr_last  = (r_hdr_cnt == CNT_W'(pHDR_WORDS - 1));
  assign w_zero_len  = (w_len_shift == '0);

  // State register; reset abandons any packet in flight.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and stream outputs. Pops are always gated by ~ififo_empty
  // because the FIFO does not guard its own read path.
  always_comb begin
    w_state_next = r_state;
    ofifo_rd     = 1'b0;
    ovalid       = 1'b0;
    osop         = 1'b0;
    oeop         = 1'b0;
    odata        = '0;
    w_hdr_pop    = 1'b0;
    w_xfer       = 1'b0;
    obusy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (ienable) w_state_next = HDR;
      end
      HDR: begin
        if (!ififo_empty) begin
          ofifo_rd  = 1'b1;
          w_hdr_pop = 1'b1;
          if (w_hdr_last) begin
            if (w_zero_len) w_state_next = ienable ? HDR : IDLE;
            else            w_state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        ovalid = !ififo_empty;
        odata  = ovalid ? ififo_data : '0;
        osop   = ovalid && (r_remain == r_len);
        oeop   = ovalid && (r_remain == LEN_W'(1));
        if (ovalid && iready) begin
          ofifo_rd = 1'b1;
          w_xfer   = 1'b1;
          if (oeop) w_state_next = ienable ? HDR : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Length assembly, header word counter and remaining-word counter.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_len     <= '0;
      r_remain  <= '0;
      r_hdr_cnt <= '0;
    end else begin
      if (w_hdr_pop) begin
        r_len     <= w_len_shift;
        r_hdr_cnt <= w_hdr_last ? '0 : r_hdr_cnt + CNT_W'(1);
        if (w_hdr_last) r_remain <= w_len_shift;
      end
      if (w_xfer) r_remain <= r_remain - LEN_W'(1);
    end
  end

`ifdef PKT_RD_STAT_EN
  logic [15:0] r_pkt_cnt;
  logic [7:0]  r_zero_cnt;

  // Wrapping counters of completed packets and zero-length headers.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_pkt_cnt  <= '0;
      r_zero_cnt <= '0;
    end else begin
      if (w_xfer && oeop)                        r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      if (w_hdr_pop && w_hdr_last && w_zero_len) r_zero_cnt <= r_zero_cnt + 8'd1;
    end
  end

  assign ostat_pkt_cnt  = r_pkt_cnt;
  assign ostat_zero_cnt = r_zero_cnt;
`endif

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Bench for pkt_fifo_reader: behavioural FWFT FIFO, scoreboard of expected
// payload beats, table of packets plus hand-written corner sequences.
module tb_pkt_fifo_reader;

  logic       iclk;
  logic       ireset;
  logic       ienable;
  logic       ififo_empty;
  logic [7:0] ififo_data;
  logic       ofifo_rd;
  logic [7:0] odata;
  logic       ovalid;
  logic       osop;
  logic       oeop;
  logic       iready;
  logic       obusy;
`ifdef PKT_RD_STAT_EN
  logic [15:0] stat_pkt;
  logic [7:0]  stat_zero;
`endif

  pkt_fifo_reader #(.pDATA_W(8), .pHDR_WORDS(2)) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .ienable     (ienable),
    .ififo_empty (ififo_empty),
    .ififo_data  (ififo_data),
    .ofifo_rd    (ofifo_rd),
    .odata       (odata),
    .ovalid      (ovalid),
    .osop        (osop),
    .oeop        (oeop),
    .iready      (iready),
    .obusy       (obusy)
`ifdef PKT_RD_STAT_EN
    ,
    .ostat_pkt_cnt  (stat_pkt),
    .ostat_zero_cnt (stat_zero)
`endif
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pops   = 0;
  int n_beats = 0;

  // Behavioural FWFT FIFO sharing the DUT reset.
  logic [7:0] mem [0:1023];
  logic [9:0] wr_ptr = '0;
  logic [9:0] rd_ptr = '0;
  assign ififo_empty = (wr_ptr == rd_ptr);
  assign ififo_data  = mem[rd_ptr];

  always @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      rd_ptr <= wr_ptr;
    end else if (ofifo_rd) begin
      n_cmp++;
      if (ififo_empty) begin
        n_fail++;
        $display("FAIL rd_on_empty: ofifo_rd=1 while FIFO empty at %0t", $time);
      end else begin
        rd_ptr <= rd_ptr + 10'd1;
        pops++;
      end
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;
  beat_t exp_q[$];

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge iclk) begin
    if (!ireset && ovalid && iready) begin
      beat_t e;
      n_cmp++;
      n_beats++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got d=%02h sop=%0b eop=%0b, none required", odata, osop, oeop);
      end else begin
        e = exp_q.pop_front();
        if ({odata, osop, oeop} !== e) begin
          n_fail++;
          $display("FAIL beat: got d=%02h sop=%0b eop=%0b, required d=%02h sop=%0b eop=%0b",
                   odata, osop, oeop, e.d, e.sop, e.eop);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic sop, input logic eop);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop;
    exp_q.push_back(b);
  endtask

  // Header then payload words base, base+1, ...; expected beats queued alongside.
  task automatic push_pkt(input int len, input logic [7:0] base);
    logic [15:0] l;
    l = 16'(len);
    push_word(l[15:8]);
    push_word(l[7:0]);
    for (int i = 0; i < len; i++) begin
      push_word(base + 8'(i));
      exp_beat(base + 8'(i), i == 0, i == len - 1);
    end
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge iclk);
      if (exp_q.size() == 0 && ififo_empty) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(done), 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, ofifo_rd, ovalid, osop, oeop, obusy, 1'b0}, 32'd0);
    check({tag, "_odata"}, 32'(odata), 32'd0);
  endtask

  typedef struct {
    int         len;
    logic [7:0] base;
    int         exp_pops;
    int         exp_beats;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int p0, p1, b0;
    bit found;
`ifdef PKT_RD_STAT_EN
    logic [15:0] sp0;
    logic [7:0]  sz0;
`endif
    vecs[0] = '{3,   8'hA1, 5,   3};
    vecs[1] = '{1,   8'h42, 3,   1};
    vecs[2] = '{0,   8'h00, 2,   0};
    vecs[3] = '{5,   8'hFD, 7,   5};
    vecs[4] = '{258, 8'h10, 260, 258};

    ireset  = 1'b1;
    ienable = 1'b0;
    iready  = 1'b1;
    tick();
    check_all_zero("reset");
    tick();
    ireset = 1'b0;
    tick();
    check("idle_busy", 32'(obusy), 32'd0);
    ienable = 1'b1;

    // Table of packets, back-to-back, full-rate sink.
    foreach (vecs[k]) begin
      p0 = pops;
      b0 = n_beats;
      push_pkt(vecs[k].len, vecs[k].base);
      wait_drain(400);
      check($sformatf("pops_v%0d", k), 32'(pops - p0), 32'(vecs[k].exp_pops));
      check($sformatf("beats_v%0d", k), 32'(n_beats - b0), 32'(vecs[k].exp_beats));
    end

    // Zero-length packet followed by a length-1 packet.
    p0 = pops;
    b0 = n_beats;
`ifdef PKT_RD_STAT_EN
    sp0 = stat_pkt;
    sz0 = stat_zero;
`endif
    push_pkt(0, 8'h00);
    push_pkt(1, 8'h5C);
    wait_drain(50);
    check("zl_pops", 32'(pops - p0), 32'd5);
    check("zl_beats", 32'(n_beats - b0), 32'd1);
`ifdef PKT_RD_STAT_EN
    check("stat_pkt", 32'(stat_pkt - sp0), 32'd1);
    check("stat_zero", 32'(stat_zero - sz0), 32'd1);
`endif

    // Back-pressure: stall 4 cycles with A2 at the head.
    p0 = pops;
    push_pkt(3, 8'hA1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      if (ovalid && osop) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_sop_seen", 32'(found), 32'd1);
    tick();
    iready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iclk);
      check("bp_hold_flags", {28'd0, ovalid, osop, oeop, ofifo_rd}, 32'b1000);
      check("bp_hold_data", 32'(odata), 32'hA2);
      check("bp_hold_pops", 32'(pops - p0), 32'd3);
    end
    tick();
    iready = 1'b1;
    wait_drain(50);
    check("bp_pops", 32'(pops - p0), 32'd5);

    // Slow writer: payload one word per 3 cycles; ienable dropped mid-packet.
    p0 = pops;
    push_word(8'h00);
    push_word(8'h04);
    repeat (3) tick();
    @(negedge iclk);
    check("uf_gap_valid", 32'(ovalid), 32'd0);
    check("uf_gap_busy", 32'(obusy), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      push_word(8'h30 + 8'(i));
      exp_beat(8'h30 + 8'(i), i == 0, i == 3);
      if (i == 1) ienable = 1'b0;
      @(negedge iclk);
      check("uf_word_valid", 32'(ovalid), 32'd1);
      tick();
      @(negedge iclk);
      check("uf_empty_valid", 32'(ovalid), 32'd0);
      tick();
      tick();
    end
    check("uf_pops", 32'(pops - p0), 32'd6);
    check("uf_idle_busy", 32'(obusy), 32'd0);

    // Disabled: a waiting packet stays in the FIFO until ienable returns.
    p1 = pops;
    push_pkt(2, 8'h77);
    repeat (5) tick();
    check("dis_pops", 32'(pops - p1), 32'd0);
    check("dis_busy", 32'(obusy), 32'd0);
    ienable = 1'b1;
    wait_drain(50);
    check("en_pops", 32'(pops - p1), 32'd4);

    // Asynchronous reset in the middle of a stalled payload.
    iready = 1'b0;
    push_pkt(3, 8'hC0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      if (ovalid) begin
        found = 1'b1;
        break;
      end
    end
    check("ar_valid_seen", 32'(found), 32'd1);
    #2;
    ireset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    tick();
    ienable = 1'b0;
    iready  = 1'b1;
    tick();
    ireset = 1'b0;
    repeat (3) tick();
    check("ar_busy", 32'(obusy), 32'd0);
    check("ar_flushed", 32'(ififo_empty), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
